async_operator_elastic: RTL and testbench

- Next-generation dataflow node for the async handshake fabric.
- Each input gets a parametrised-depth FIFO, and the operand count is generalised to 1..3.
- Each output consumer is acknowledged independently, so one token is delivered exactly once to every consumer without all consumers requesting in the same cycle.
- Sits between producers/other nodes and consumers/other nodes inside generated dataflow graphs.

---
 rtl/async_operator_elastic.sv | 163 ++++++++++++++++
 tb/tb_async_operator_elastic.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/async_operator_elastic.sv
// async_operator_elastic
// ----------------------
// Elastic dataflow node for the async handshake fabric. Each operand input
// is buffered in its own DEPTH-entry FIFO. When every FIFO holds a token
// and the previous result has been handed to all consumers, one token is
// popped from each FIFO and the result is loaded into dout. Each consumer
// then receives a one-cycle ack_r independently, exactly once per result.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   req_l[INPUTS]     per-input request to upstream (level, registered)
//   ack_l[INPUTS]     per-input one-cycle acknowledge, din slice valid with it
//   din               operand i at [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i]
//   req_r[OUTPUTS]    per-consumer request
//   ack_r[OUTPUTS]    per-consumer one-cycle acknowledge, dout valid while high
//   dout              result register
//   fire_count        results computed since reset (wraps)
//   overflow          sticky: an ack_l arrived while its FIFO was full
//
// OP: "pass", "addi", "subi", "muli" (INPUTS==1), "add", "sub", "mul".
// DEPTH must be a power of two and at least 2.
module async_operator_elastic #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    INPUTS     = 2,
  parameter int                    OUTPUTS    = 1,
  parameter int                    DEPTH      = 4,
  parameter string                 OP         = "add",
  parameter logic [DATA_WIDTH-1:0] IMMEDIATE  = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [INPUTS-1:0]            req_l,
  input  logic [INPUTS-1:0]            ack_l,
  input  logic [DATA_WIDTH*INPUTS-1:0] din,
  input  logic [OUTPUTS-1:0]           req_r,
  output logic [OUTPUTS-1:0]           ack_r,
  output logic [DATA_WIDTH-1:0]        dout,
  output logic [31:0]                  fire_count,
  output logic                         overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] OPC_PASS = 3'd0;
  localparam logic [2:0] OPC_ADDI = 3'd1;
  localparam logic [2:0] OPC_SUBI = 3'd2;
  localparam logic [2:0] OPC_MULI = 3'd3;
  localparam logic [2:0] OPC_ADD  = 3'd4;
  localparam logic [2:0] OPC_SUB  = 3'd5;
  localparam logic [2:0] OPC_MUL  = 3'd6;

  localparam logic [2:0] OPC = (OP == "pass") ? OPC_PASS :
                               (OP == "addi") ? OPC_ADDI :
                               (OP == "subi") ? OPC_SUBI :
                               (OP == "muli") ? OPC_MULI :
                               (OP == "sub")  ? OPC_SUB  :
                               (OP == "mul")  ? OPC_MUL  : OPC_ADD;

  logic [INPUTS-1:0]     w_nonempty;
  logic [INPUTS-1:0]     w_push;
  logic [INPUTS-1:0]     w_drop;
  logic [DATA_WIDTH-1:0] w_head [INPUTS];
  logic                  w_fire;
  logic [DATA_WIDTH-1:0] w_result;
  logic [OUTPUTS-1:0]    w_deliver;

  logic [OUTPUTS-1:0]    r_pending;
  logic [OUTPUTS-1:0]    r_ack_r;
  logic [DATA_WIDTH-1:0] r_dout;
  logic [31:0]           r_fire_count;
  logic                  r_overflow;

  // A new result may only be produced once every consumer has taken the
  // previous one; pending doubles as the "dout is still owed" flag.
  assign w_fire = (&w_nonempty) && (r_pending == '0);

  generate
    for (genvar gi = 0; gi < INPUTS; gi++) begin : g_fifo
      logic [DATA_WIDTH-1:0] r_mem [DEPTH];
      logic [AW-1:0]         r_wr_ptr;
      logic [AW-1:0]         r_rd_ptr;
      logic [CW-1:0]         r_count;
      logic                  r_req;
      logic                  w_full;
      logic [CW-1:0]         w_count_next;

      assign w_full         = (r_count == CW'(DEPTH));
      assign w_nonempty[gi] = (r_count != '0);
      // A full FIFO that pops on this edge frees the slot the push needs.
      assign w_push[gi]     = ack_l[gi] && (!w_full || w_fire);
      assign w_drop[gi]     = ack_l[gi] && w_full && !w_fire;
      // Head is read combinationally so the fire edge can use it directly.
      assign w_head[gi]     = r_mem[r_rd_ptr];
      assign w_count_next   = r_count + CW'(w_push[gi]) - CW'(w_fire);
      assign req_l[gi]      = r_req;

      always_ff @(posedge clk) begin
        if (w_push[gi]) begin
          r_mem[r_wr_ptr] <= din[DATA_WIDTH*gi +: DATA_WIDTH];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_count  <= '0;
          r_req    <= 1'b0;
        end else begin
          if (w_push[gi]) r_wr_ptr <= r_wr_ptr + AW'(1);
          if (w_fire)     r_rd_ptr <= r_rd_ptr + AW'(1);
          r_count <= w_count_next;
          // One slot stays reserved for an ack that is already in flight
          // when upstream sees req_l fall.
          r_req   <= (w_count_next <= CW'(DEPTH - 2));
        end
      end
    end
  endgenerate

  always_comb begin
    w_result = w_head[0];
    case (OPC)
      OPC_ADDI: w_result = w_head[0] + IMMEDIATE;
      OPC_SUBI: w_result = w_head[0] - IMMEDIATE;
      OPC_MULI: w_result = w_head[0] * IMMEDIATE;
      OPC_ADD:  for (int k = 1; k < INPUTS; k++) w_result = w_result + w_head[k];
      OPC_SUB:  for (int k = 1; k < INPUTS; k++) w_result = w_result - w_head[k];
      OPC_MUL:  for (int k = 1; k < INPUTS; k++) w_result = w_result * w_head[k];
      default:  w_result = w_head[0];
    endcase
  end

  // Skipping a cycle after each ack keeps ack_r to one cycle per token.
  assign w_deliver = r_pending & req_r & ~r_ack_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending    <= '0;
      r_ack_r      <= '0;
      r_dout       <= '0;
      r_fire_count <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_ack_r <= w_deliver;
      if (w_fire) begin
        r_pending    <= '1;
        r_dout       <= w_result;
        r_fire_count <= r_fire_count + 32'd1;
      end else begin
        r_pending <= r_pending & ~w_deliver;
      end
      if (|w_drop) r_overflow <= 1'b1;
    end
  end

  assign ack_r      = r_ack_r;
  assign dout       = r_dout;
  assign fire_count = r_fire_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_async_operator_elastic.sv
// Directed bench for async_operator_elastic using three instances:
//   A: add,  INPUTS=2, OUTPUTS=1, DEPTH=4
//   B: sub,  INPUTS=3, OUTPUTS=3, DEPTH=4
//   C: muli, INPUTS=1, OUTPUTS=1, IMMEDIATE=3
module tb_async_operator_elastic;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  a_req_l, a_ack_l;
  logic [63:0] a_din;
  logic [0:0]  a_req_r, a_ack_r;
  logic [31:0] a_dout, a_fc;
  logic        a_ovf;

  logic [2:0]  b_req_l, b_ack_l;
  logic [95:0] b_din;
  logic [2:0]  b_req_r, b_ack_r;
  logic [31:0] b_dout, b_fc;
  logic        b_ovf;

  logic [0:0]  c_req_l, c_ack_l;
  logic [31:0] c_din;
  logic [0:0]  c_req_r, c_ack_r;
  logic [31:0] c_dout, c_fc;
  logic        c_ovf;

  int n_pass = 0;
  int n_total = 0;

  async_operator_elastic #(.DATA_WIDTH(32), .INPUTS(2), .OUTPUTS(1), .DEPTH(4), .OP("add")) dut_a (
    .clk(clk), .rst(rst), .req_l(a_req_l), .ack_l(a_ack_l), .din(a_din), .req_r(a_req_r),
    .ack_r(a_ack_r), .dout(a_dout), .fire_count(a_fc), .overflow(a_ovf));

  async_operator_elastic #(.DATA_WIDTH(32), .INPUTS(3), .OUTPUTS(3), .DEPTH(4), .OP("sub")) dut_b (
    .clk(clk), .rst(rst), .req_l(b_req_l), .ack_l(b_ack_l), .din(b_din), .req_r(b_req_r),
    .ack_r(b_ack_r), .dout(b_dout), .fire_count(b_fc), .overflow(b_ovf));

  async_operator_elastic #(.DATA_WIDTH(32), .INPUTS(1), .OUTPUTS(1), .DEPTH(4), .OP("muli"),
                           .IMMEDIATE(32'd3)) dut_c (
    .clk(clk), .rst(rst), .req_l(c_req_l), .ack_l(c_ack_l), .din(c_din), .req_r(c_req_r),
    .ack_r(c_ack_r), .dout(c_dout), .fire_count(c_fc), .overflow(c_ovf));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_ack_l = '0; a_din = '0; a_req_r = '0;
    b_ack_l = '0; b_din = '0; b_req_r = '0;
    c_ack_l = '0; c_din = '0; c_req_r = '0;
    tick(); tick();
    n_total++; if (a_req_l !== 2'b00) $display("FAIL reset_req_l: got %b expected 00", a_req_l); else n_pass++;
    n_total++; if (a_ack_r !== 1'b0) $display("FAIL reset_ack_r: got %b expected 0", a_ack_r); else n_pass++;
    n_total++; if (a_dout !== 32'd0) $display("FAIL reset_dout: got %h expected 0", a_dout); else n_pass++;
    n_total++; if (a_fc !== 32'd0) $display("FAIL reset_fire_count: got %0d expected 0", a_fc); else n_pass++;
    n_total++; if (a_ovf !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", a_ovf); else n_pass++;
    n_total++; if (b_ack_r !== 3'b000) $display("FAIL reset_b_ack_r: got %b expected 000", b_ack_r); else n_pass++;
    rst = 1'b0;
    tick();
    n_total++; if (a_req_l !== 2'b11) $display("FAIL req_l_after_reset: got %b expected 11", a_req_l); else n_pass++;
    n_total++; if (b_req_l !== 3'b111) $display("FAIL b_req_l_after_reset: got %b expected 111", b_req_l); else n_pass++;
  endtask

  task automatic test_add();
    a_req_r = 1'b1;
    a_ack_l = 2'b11; a_din = {32'd4, 32'd3};
    tick();
    a_ack_l = 2'b00;
    tick();
    n_total++; if (a_dout !== 32'd7) $display("FAIL add_dout_7: got %h expected 7", a_dout); else n_pass++;
    n_total++; if (a_fc !== 32'd1) $display("FAIL add_fc_1: got %0d expected 1", a_fc); else n_pass++;
    n_total++; if (a_ack_r !== 1'b0) $display("FAIL add_ack_r_fire_cycle: got %b expected 0", a_ack_r); else n_pass++;
    tick();
    n_total++; if (a_ack_r !== 1'b1) $display("FAIL add_ack_r_first: got %b expected 1", a_ack_r); else n_pass++;
    a_ack_l = 2'b11; a_din = {32'd20, 32'd10};
    tick();
    a_ack_l = 2'b00;
    n_total++; if (a_ack_r !== 1'b0) $display("FAIL add_ack_r_single_cycle: got %b expected 0", a_ack_r); else n_pass++;
    tick();
    n_total++; if (a_dout !== 32'd30) $display("FAIL add_dout_30: got %h expected 1e", a_dout); else n_pass++;
    tick();
    n_total++; if (a_ack_r !== 1'b1) $display("FAIL add_ack_r_second: got %b expected 1", a_ack_r); else n_pass++;
    tick();
    n_total++; if (a_fc !== 32'd2) $display("FAIL add_fc_2: got %0d expected 2", a_fc); else n_pass++;
    n_total++; if (a_ack_r !== 1'b0) $display("FAIL add_ack_r_idle: got %b expected 0", a_ack_r); else n_pass++;
  endtask

  task automatic test_sub_wrap();
    b_req_r = 3'b111;
    b_ack_l = 3'b111; b_din = {32'd1, 32'd7, 32'd5};
    tick();
    b_ack_l = 3'b000;
    tick();
    n_total++; if (b_dout !== 32'hFFFF_FFFD) $display("FAIL sub_wrap_dout: got %h expected fffffffd", b_dout); else n_pass++;
    tick();
    n_total++; if (b_ack_r !== 3'b111) $display("FAIL sub_ack_r_all: got %b expected 111", b_ack_r); else n_pass++;
    tick();
    n_total++; if (b_ack_r !== 3'b000) $display("FAIL sub_ack_r_drop: got %b expected 000", b_ack_r); else n_pass++;
  endtask

  task automatic test_muli();
    c_req_r = 1'b1;
    c_ack_l = 1'b1; c_din = 32'h6000_0000;
    tick();
    c_ack_l = 1'b0;
    tick();
    n_total++; if (c_dout !== 32'h2000_0000) $display("FAIL muli_dout: got %h expected 20000000", c_dout); else n_pass++;
    tick();
    n_total++; if (c_ack_r !== 1'b1) $display("FAIL muli_ack_r: got %b expected 1", c_ack_r); else n_pass++;
    n_total++; if (c_fc !== 32'd1) $display("FAIL muli_fc: got %0d expected 1", c_fc); else n_pass++;
  endtask

  task automatic test_fork();
    b_req_r = 3'b001;
    b_ack_l = 3'b111; b_din = {32'd2, 32'd3, 32'd10};
    tick();
    b_din = {32'd1, 32'd1, 32'd20};
    tick();
    b_ack_l = 3'b000;
    n_total++; if (b_dout !== 32'd5) $display("FAIL fork_dout_first: got %h expected 5", b_dout); else n_pass++;
    tick();
    n_total++; if (b_ack_r !== 3'b001) $display("FAIL fork_ack_c0: got %b expected 001", b_ack_r); else n_pass++;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_total++; if (b_ack_r !== 3'b000) $display("FAIL fork_c0_once cyc%0d: got %b expected 000", c, b_ack_r); else n_pass++;
      n_total++; if (b_fc !== 32'd2) $display("FAIL fork_no_second_fire cyc%0d: got %0d expected 2", c, b_fc); else n_pass++;
    end
    b_req_r = 3'b110;
    tick();
    n_total++; if (b_ack_r !== 3'b110) $display("FAIL fork_ack_c12: got %b expected 110", b_ack_r); else n_pass++;
    n_total++; if (b_dout !== 32'd5) $display("FAIL fork_dout_held: got %h expected 5", b_dout); else n_pass++;
    tick();
    n_total++; if (b_fc !== 32'd3) $display("FAIL fork_second_fire: got %0d expected 3", b_fc); else n_pass++;
    n_total++; if (b_dout !== 32'd18) $display("FAIL fork_dout_second: got %h expected 12", b_dout); else n_pass++;
    n_total++; if (b_ack_r !== 3'b000) $display("FAIL fork_ack_gap: got %b expected 000", b_ack_r); else n_pass++;
    tick();
    n_total++; if (b_ack_r !== 3'b110) $display("FAIL fork_ack2_c12: got %b expected 110", b_ack_r); else n_pass++;
    tick();
    b_req_r = 3'b001;
    tick();
    n_total++; if (b_ack_r !== 3'b001) $display("FAIL fork_ack2_c0: got %b expected 001", b_ack_r); else n_pass++;
    tick();
    n_total++; if (b_fc !== 32'd3) $display("FAIL fork_no_fire_empty: got %0d expected 3", b_fc); else n_pass++;
  endtask

  task automatic test_backpressure();
    int n_ack;
    a_req_r = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      a_ack_l = 2'b01; a_din = {32'd0, 32'(k)};
      tick();
      if (k == 2) begin
        n_total++; if (a_req_l !== 2'b11) $display("FAIL bp_req_l_occ2: got %b expected 11", a_req_l); else n_pass++;
      end
      if (k == 3) begin
        n_total++; if (a_req_l !== 2'b10) $display("FAIL bp_req_l_occ3: got %b expected 10", a_req_l); else n_pass++;
      end
      if (k == 4) begin
        n_total++; if (a_ovf !== 1'b0) $display("FAIL bp_ovf_occ4: got %b expected 0", a_ovf); else n_pass++;
      end
    end
    a_ack_l = 2'b00;
    n_total++; if (a_ovf !== 1'b1) $display("FAIL bp_ovf_set: got %b expected 1", a_ovf); else n_pass++;
    a_req_r = 1'b1;
    n_ack = 0;
    for (int c = 0; c < 14; c++) begin
      a_ack_l = (c < 4) ? 2'b10 : 2'b00;
      a_din = {32'd100, 32'd0};
      tick();
      if (a_ack_r === 1'b1) begin
        n_total++;
        if (a_dout !== 32'(101 + n_ack)) $display("FAIL bp_drain_dout%0d: got %0d expected %0d", n_ack, a_dout, 101 + n_ack);
        else n_pass++;
        n_ack++;
      end
    end
    a_ack_l = 2'b00;
    n_total++; if (n_ack != 4) $display("FAIL bp_drain_count: got %0d expected 4", n_ack); else n_pass++;
    n_total++; if (a_fc !== 32'd6) $display("FAIL bp_fc: got %0d expected 6", a_fc); else n_pass++;
    n_total++; if (a_ovf !== 1'b1) $display("FAIL bp_ovf_sticky: got %b expected 1", a_ovf); else n_pass++;
    n_total++; if (a_req_l !== 2'b11) $display("FAIL bp_req_l_drained: got %b expected 11", a_req_l); else n_pass++;
  endtask

  task automatic test_skew();
    a_req_r = 1'b1;
    a_ack_l = 2'b01; a_din = {32'd0, 32'd50};
    tick();
    a_ack_l = 2'b00;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_total++; if (a_fc !== 32'd6) $display("FAIL skew_early_fire cyc%0d: got %0d expected 6", c, a_fc); else n_pass++;
    end
    a_ack_l = 2'b10; a_din = {32'd8, 32'd0};
    tick();
    a_ack_l = 2'b00;
    n_total++; if (a_fc !== 32'd6) $display("FAIL skew_fire_on_capture: got %0d expected 6", a_fc); else n_pass++;
    tick();
    n_total++; if (a_fc !== 32'd7) $display("FAIL skew_fire: got %0d expected 7", a_fc); else n_pass++;
    n_total++; if (a_dout !== 32'd58) $display("FAIL skew_dout: got %0d expected 58", a_dout); else n_pass++;
    tick();
    n_total++; if (a_ack_r !== 1'b1) $display("FAIL skew_ack_r: got %b expected 1", a_ack_r); else n_pass++;
  endtask

  task automatic test_reset_midstream();
    b_req_r = 3'b000;
    b_ack_l = 3'b111; b_din = {32'd3, 32'd2, 32'd9};
    tick();
    b_din = {32'd1, 32'd1, 32'd8};
    tick();
    b_din = {32'd1, 32'd1, 32'd7};
    tick();
    b_ack_l = 3'b000;
    n_total++; if (b_fc !== 32'd4) $display("FAIL mid_fc_before: got %0d expected 4", b_fc); else n_pass++;
    n_total++; if (b_dout !== 32'd4) $display("FAIL mid_dout_before: got %0d expected 4", b_dout); else n_pass++;
    rst = 1'b1;
    tick();
    n_total++; if (b_req_l !== 3'b000) $display("FAIL mid_rst_req_l: got %b expected 000", b_req_l); else n_pass++;
    n_total++; if (b_dout !== 32'd0) $display("FAIL mid_rst_dout: got %h expected 0", b_dout); else n_pass++;
    n_total++; if (b_fc !== 32'd0) $display("FAIL mid_rst_fc: got %0d expected 0", b_fc); else n_pass++;
    n_total++; if (a_ovf !== 1'b0) $display("FAIL mid_rst_ovf: got %b expected 0", a_ovf); else n_pass++;
    rst = 1'b0;
    b_req_r = 3'b111;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_total++; if (b_ack_r !== 3'b000) $display("FAIL mid_stale_ack cyc%0d: got %b expected 000", c, b_ack_r); else n_pass++;
      n_total++; if (b_fc !== 32'd0) $display("FAIL mid_stale_fire cyc%0d: got %0d expected 0", c, b_fc); else n_pass++;
    end
    n_total++; if (b_req_l !== 3'b111) $display("FAIL mid_req_l_after: got %b expected 111", b_req_l); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_wrap();
    test_muli();
    test_fork();
    test_backpressure();
    test_skew();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
